// File: rtl/mdio_master.sv
// MAC-side MDIO master: divides clk down to MDC, serialises a 32-bit management frame and
// shifts in read data. Define MDIO_PREAMBLE_EN to prefix every frame with 32 preamble ones.
module mdio_master #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MDC_START,
  input  logic [31:0] T_DATA,
  input  logic        MDIO_IN,
  output logic        MDC,
  output logic        MDIO_OUT,
  output logic        MDIO_OE,
  output logic [15:0] RD_DATA,
  output logic        DATA_RDY,
  output logic        BUSY
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    StIdle,
`ifdef MDIO_PREAMBLE_EN
    StPreamble,
`endif
    StHeader,
    StWriteTail,
    StTurn,
    StReadData
  } state_e;

  logic [DivW-1:0] div_cnt;
  logic            wrap;
  logic            fall_evt;
  logic            rise_evt;

  state_e      state;
  logic [31:0] tx_sr;
  logic [14:0] rx_sr;
  logic [5:0]  bit_cnt;
  logic        is_read;

  assign wrap     = (div_cnt == DivW'(CLK_DIV - 1));
  assign fall_evt = wrap & MDC;
  assign rise_evt = wrap & ~MDC;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      MDC     <= 1'b0;
    end else if (wrap) begin
      div_cnt <= '0;
      MDC     <= ~MDC;
    end else begin
      div_cnt <= div_cnt + DivW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= StIdle;
      tx_sr    <= '0;
      rx_sr    <= '0;
      bit_cnt  <= '0;
      is_read  <= 1'b0;
      MDIO_OUT <= 1'b0;
      MDIO_OE  <= 1'b0;
      RD_DATA  <= '0;
      DATA_RDY <= 1'b0;
      BUSY     <= 1'b0;
    end else begin
      DATA_RDY <= 1'b0;
      unique case (state)
        StIdle: begin
          if (MDC_START) begin
            tx_sr   <= T_DATA;
            is_read <= (T_DATA[29:28] == 2'b10);
            bit_cnt <= '0;
            BUSY    <= 1'b1;
`ifdef MDIO_PREAMBLE_EN
            state   <= StPreamble;
`else
            state   <= StHeader;
`endif
          end
        end
`ifdef MDIO_PREAMBLE_EN
        StPreamble: begin
          if (fall_evt) begin
            MDIO_OUT <= 1'b1;
            MDIO_OE  <= 1'b1;
            if (bit_cnt == 6'd31) begin
              bit_cnt <= '0;
              state   <= StHeader;
            end else begin
              bit_cnt <= bit_cnt + 6'd1;
            end
          end
        end
`endif
        StHeader: begin
          if (fall_evt) begin
            MDIO_OUT <= tx_sr[31];
            MDIO_OE  <= 1'b1;
            tx_sr    <= {tx_sr[30:0], 1'b0};
            if (bit_cnt == 6'd13) begin
              bit_cnt <= '0;
              state   <= is_read ? StTurn : StWriteTail;
            end else begin
              bit_cnt <= bit_cnt + 6'd1;
            end
          end
        end
        StWriteTail: begin
          if (fall_evt) begin
            if (bit_cnt == 6'd18) begin
              MDIO_OUT <= 1'b0;
              MDIO_OE  <= 1'b0;
              BUSY     <= 1'b0;
              bit_cnt  <= '0;
              state    <= StIdle;
            end else begin
              MDIO_OUT <= tx_sr[31];
              MDIO_OE  <= 1'b1;
              tx_sr    <= {tx_sr[30:0], 1'b0};
              bit_cnt  <= bit_cnt + 6'd1;
            end
          end
        end
        // Two TA periods released; the third fall starts the PHY's data bit 15.
        StTurn: begin
          if (fall_evt) begin
            MDIO_OUT <= 1'b0;
            MDIO_OE  <= 1'b0;
            if (bit_cnt == 6'd2) begin
              bit_cnt <= '0;
              state   <= StReadData;
            end else begin
              bit_cnt <= bit_cnt + 6'd1;
            end
          end
        end
        StReadData: begin
          if (rise_evt && (bit_cnt != 6'd16)) begin
            rx_sr   <= {rx_sr[13:0], MDIO_IN};
            bit_cnt <= bit_cnt + 6'd1;
            if (bit_cnt == 6'd15) begin
              RD_DATA  <= {rx_sr, MDIO_IN};
              DATA_RDY <= 1'b1;
            end
          end
          if (fall_evt && (bit_cnt == 6'd16)) begin
            BUSY    <= 1'b0;
            bit_cnt <= '0;
            state   <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_master.sv
// Bench for mdio_master: three instances (CLK_DIV 2, 1, 5) share stimulus; per-instance
// monitors log each MDC period's line state and a PHY model returns read data.
module tb_mdio_master;

`ifdef MDIO_PREAMBLE_EN
  localparam int Pre = 32;
`else
  localparam int Pre = 0;
`endif
  localparam int Len = Pre + 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mdc_start = 1'b0;
  logic [31:0] t_data = '0;
  logic [15:0] phy_words [0:63];

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int Div = (g == 0) ? 2 : ((g == 1) ? 1 : 5);
    logic        mdc, mdio_out, mdio_oe, data_rdy, busy;
    logic [15:0] rd_data;
    logic        mdio_in = 1'b0;

    mdio_master #(.CLK_DIV(Div)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .MDC_START(mdc_start),
      .T_DATA   (t_data),
      .MDIO_IN  (mdio_in),
      .MDC      (mdc),
      .MDIO_OUT (mdio_out),
      .MDIO_OE  (mdio_oe),
      .RD_DATA  (rd_data),
      .DATA_RDY (data_rdy),
      .BUSY     (busy)
    );

    logic        mdc_prev = 1'b0, busy_prev = 1'b0, frame_done = 1'b0;
    int          cyc = 0, fidx = -1, frame_no = 0, end_fall = -1, gap = 0;
    int          t_acc = 0, t_first = 0, t_end = 0, t_rdy = 0, rdy_cnt = 0, rdy_total = 0;
    logic [95:0] out_bits = '0, oe_bits = '0;
    logic [15:0] rd_hist [0:63];

    // Slot k is the k-th MDC fall after acceptance; the PHY drives data bits in slots 16..31.
    always @(negedge clk) begin
      cyc++;
      if (!rst) begin
        if (busy && !busy_prev) begin
          frame_no++;
          fidx = -1; out_bits = '0; oe_bits = '0; rdy_cnt = 0; end_fall = -1;
          frame_done = 1'b0; gap = cyc - t_end; t_acc = cyc;
        end else if (mdc_prev && !mdc && (busy || busy_prev)) begin
          fidx++;
          if (fidx < 96) begin
            out_bits[fidx] = mdio_out;
            oe_bits[fidx]  = mdio_oe;
          end
          if (fidx == 0) t_first = cyc;
          if (!busy) begin
            end_fall = fidx; t_end = cyc; frame_done = 1'b1;
          end
          if (fidx >= Pre + 16 && fidx <= Pre + 31)
            mdio_in = phy_words[frame_no % 64][Pre + 31 - fidx];
          else
            mdio_in = 1'($urandom);
        end
        if (data_rdy) begin
          rdy_cnt++; t_rdy = cyc;
          rd_hist[rdy_total % 64] = rd_data;
          rdy_total++;
        end
      end
      mdc_prev  = mdc;
      busy_prev = busy;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag, input logic mdc, input logic out, input logic oe,
                          input logic busy, input logic rdy, input logic [15:0] rd);
    chk(tag, 96'({mdc, out, oe, busy, rdy, rd}), 96'd0);
  endtask

  // Expected line contents come straight from the frame word: preamble ones, then T_DATA
  // MSB-first; read frames release the line after 14 bits. Slot Len terminates the frame.
  task automatic check_frame(input string tag, input int div, input logic [31:0] td,
                             input logic [15:0] phy, input logic [95:0] ob,
                             input logic [95:0] eb, input int endf, input int ta,
                             input int tf, input int te, input int tr, input int nrdy,
                             input logic [15:0] rd);
    logic [95:0] exp_oe, exp_out, mask;
    bit          rd_frame;
    rd_frame = (td[29:28] == 2'b10);
    exp_oe = '0; exp_out = '0; mask = '0;
    for (int i = 0; i <= Len; i++) begin
      mask[i] = 1'b1;
      if (i < Pre) begin
        exp_oe[i] = 1'b1; exp_out[i] = 1'b1;
      end else if (i < Len) begin
        exp_out[i] = td[31 - (i - Pre)];
        exp_oe[i]  = !rd_frame || ((i - Pre) < 14);
      end
    end
    chk({tag, ".oe"}, eb & mask, exp_oe);
    chk({tag, ".out"}, ob & exp_oe, exp_out & exp_oe);
    chk_int({tag, ".end_slot"}, endf, Len);
    chk_int({tag, ".frame_clks"}, te - tf, Len * 2 * div);
    chk({tag, ".start_lat"}, 96'((tf - ta >= 1) && (tf - ta <= 2 * div)), 96'd1);
    if (rd_frame) begin
      chk_int({tag, ".rdy_cnt"}, nrdy, 1);
      chk({tag, ".rd_data"}, 96'(rd), 96'(phy));
      chk_int({tag, ".rdy_time"}, tr - tf, (Len - 1) * 2 * div + div);
    end else begin
      chk_int({tag, ".rdy_cnt"}, nrdy, 0);
    end
  endtask

  task automatic run_frame(input logic [31:0] td, input logic [15:0] phy, input bit inject);
    int nf;
    nf = g_dut[0].frame_no + 1;
    phy_words[nf % 64] = phy;
    tick;
    mdc_start = 1'b1; t_data = td;
    tick;
    mdc_start = 1'b0; t_data = $urandom;
    tick;
    if (inject) begin
      for (int i = 0; i < 400 && g_dut[0].fidx != 10; i++) tick;
      mdc_start = 1'b1; t_data = 32'h5000_0000;
      tick;
      mdc_start = 1'b0;
    end
    for (int i = 0; i < 4000 && !(g_dut[0].frame_done && g_dut[1].frame_done &&
                                 g_dut[2].frame_done); i++) tick;
    chk("frame_done", 96'({g_dut[0].frame_done, g_dut[1].frame_done, g_dut[2].frame_done}),
        96'd7);
    check_frame("div2", 2, td, phy, g_dut[0].out_bits, g_dut[0].oe_bits, g_dut[0].end_fall,
                g_dut[0].t_acc, g_dut[0].t_first, g_dut[0].t_end, g_dut[0].t_rdy,
                g_dut[0].rdy_cnt, g_dut[0].rd_data);
    check_frame("div1", 1, td, phy, g_dut[1].out_bits, g_dut[1].oe_bits, g_dut[1].end_fall,
                g_dut[1].t_acc, g_dut[1].t_first, g_dut[1].t_end, g_dut[1].t_rdy,
                g_dut[1].rdy_cnt, g_dut[1].rd_data);
    check_frame("div5", 5, td, phy, g_dut[2].out_bits, g_dut[2].oe_bits, g_dut[2].end_fall,
                g_dut[2].t_acc, g_dut[2].t_first, g_dut[2].t_end, g_dut[2].t_rdy,
                g_dut[2].rdy_cnt, g_dut[2].rd_data);
  endtask

  initial begin
    int          n0, r0, f0;
    logic [31:0] td;
    for (int i = 0; i < 64; i++) phy_words[i] = 16'($urandom);

    // Reset values.
    tick;
    tick;
    chk_zero("rst.div2", g_dut[0].mdc, g_dut[0].mdio_out, g_dut[0].mdio_oe, g_dut[0].busy,
             g_dut[0].data_rdy, g_dut[0].rd_data);
    chk_zero("rst.div1", g_dut[1].mdc, g_dut[1].mdio_out, g_dut[1].mdio_oe, g_dut[1].busy,
             g_dut[1].data_rdy, g_dut[1].rd_data);
    chk_zero("rst.div5", g_dut[2].mdc, g_dut[2].mdio_out, g_dut[2].mdio_oe, g_dut[2].busy,
             g_dut[2].data_rdy, g_dut[2].rd_data);
    rst = 1'b0;

    // Directed write and read frames.
    run_frame(32'h5086_ABCD, 16'h0000, 1'b0);
    run_frame(32'h6086_0000, 16'hBEEF, 1'b0);

    // Start request while busy must not disturb the frame in flight.
    f0 = g_dut[0].frame_no;
    run_frame(32'h5CA5_1234, 16'h0000, 1'b1);
    repeat (20) tick;
    chk_int("busy_start.frames", g_dut[0].frame_no, f0 + 1);
    chk("busy_start.idle", 96'(g_dut[0].busy), 96'd0);

    // Randomised frames, alternating forced reads with arbitrary opcodes.
    for (int i = 0; i < 6; i++) begin
      td = $urandom;
      if (i % 2 == 1) td[29:28] = 2'b10;
      run_frame(td, 16'($urandom), 1'b0);
    end

    // Reset during data bit 8 of a read.
    n0 = g_dut[0].frame_no;
    phy_words[(n0 + 1) % 64] = 16'h5A5A;
    tick;
    mdc_start = 1'b1; t_data = 32'h6086_0000;
    tick;
    mdc_start = 1'b0;
    tick;
    for (int i = 0; i < 400 && g_dut[0].fidx != Pre + 23; i++) tick;
    chk_int("rst_mid.reached", g_dut[0].fidx, Pre + 23);
    r0 = g_dut[0].rdy_total;
    rst = 1'b1;
    tick;
    chk_zero("rst_mid.outs", g_dut[0].mdc, g_dut[0].mdio_out, g_dut[0].mdio_oe, g_dut[0].busy,
             g_dut[0].data_rdy, g_dut[0].rd_data);
    tick;
    rst = 1'b0;
    repeat (300) tick;
    chk_int("rst_mid.no_rdy", g_dut[0].rdy_total, r0);
    chk("rst_mid.rd_held", 96'({g_dut[0].busy, g_dut[0].rd_data}), 96'd0);
    run_frame(32'h6086_0000, 16'hC3A7, 1'b0);

    // Back-to-back reads with MDC_START held high.
    n0 = g_dut[0].frame_no;
    r0 = g_dut[0].rdy_total;
    phy_words[(n0 + 1) % 64] = 16'h1234;
    phy_words[(n0 + 2) % 64] = 16'hFFFF;
    tick;
    mdc_start = 1'b1; t_data = 32'h6086_0000;
    for (int i = 0; i < 4000 && g_dut[0].frame_no != n0 + 2; i++) tick;
    mdc_start = 1'b0;
    chk_int("b2b.accepts", g_dut[0].frame_no, n0 + 2);
    chk_int("b2b.gap", g_dut[0].gap, 1);
    tick;
    for (int i = 0; i < 4000 && !g_dut[0].frame_done; i++) tick;
    chk_int("b2b.rdy_total", g_dut[0].rdy_total, r0 + 2);
    chk("b2b.first", 96'(g_dut[0].rd_hist[r0 % 64]), 96'h1234);
    chk("b2b.second", 96'(g_dut[0].rd_hist[(r0 + 1) % 64]), 96'hFFFF);
    chk("b2b.rd_data", 96'(g_dut[0].rd_data), 96'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
